// File: rtl/pe_feed_seq_pkg.sv
// pe_feed_seq_pkg: shared PE packet types, FSM states and sizing defaults for the PE feed sequencer.
package pe_feed_seq_pkg;
  localparam int KTAPS_DEF = 9;
  localparam int POOL_WIN_DEF = 4;
  localparam int NLANES = 4;
  typedef enum logic [2:0] {
    INVALID  = 3'd0,
    VALID    = 3'd1,
    CNN_FIN  = 3'd2,
    POOL_FIN = 3'd3
  } pe_state_t;
  typedef enum logic [1:0] {S_IDLE, S_LOAD_W, S_STREAM, S_FIN} seq_state_t;
  typedef struct packed {
    pe_state_t               state;
    logic [NLANES-1:0][7:0]  a;
    logic [7:0]              wrb_data;
    logic [3:0]              wrb_addr;
    logic [NLANES-1:0]       wrb;
    logic [3:0]              rdb_addr;
  } pe_in_packet_t;
  function automatic pe_state_t last_tap_tag(input logic pool_last);
    return pool_last ? POOL_FIN : CNN_FIN;
  endfunction
endpackage

// File: rtl/pe_feed_seq_ctr.sv
// pe_feed_ctr: tap/window/pool-group counters with wrap and terminal-count flags.
module pe_feed_ctr
  import pe_feed_seq_pkg::*;
#(
  parameter int KTAPS    = KTAPS_DEF,
  parameter int POOL_WIN = POOL_WIN_DEF,
  parameter int NWIN_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clr,
  input  logic              i_adv,
  input  logic [NWIN_W-1:0] i_num_win,
  output logic [3:0]        o_tap,
  output logic              o_tap_last,
  output logic              o_win_last,
  output logic              o_pool_last
);
  localparam int PW = POOL_WIN > 1 ? $clog2(POOL_WIN) : 1;
  logic [3:0]        r_tap;
  logic [NWIN_W-1:0] r_win;
  logic [PW-1:0]     r_pool;
  assign o_tap       = r_tap;
  assign o_tap_last  = r_tap == 4'(KTAPS - 1);
  assign o_win_last  = r_win == i_num_win - NWIN_W'(1);
  assign o_pool_last = r_pool == PW'(POOL_WIN - 1);
  // pool counter tracks win % POOL_WIN across the whole job
  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_tap  <= '0;
      r_win  <= '0;
      r_pool <= '0;
    end else if (i_adv) begin
      r_tap <= o_tap_last ? '0 : r_tap + 4'd1;
      if (o_tap_last) begin
        r_win  <= r_win + NWIN_W'(1);
        r_pool <= o_pool_last ? '0 : r_pool + PW'(1);
      end
    end
  end
endmodule

// File: rtl/pe_feed_seq.sv
// pe_feed_seq: loads KTAPS weights then streams tagged activation packets to the PE pipeline.
// Optional PE_FEED_PERF_EN adds stall_cnt/beat_cnt performance counters.
module pe_feed_seq
  import pe_feed_seq_pkg::*;
#(
  parameter int KTAPS    = KTAPS_DEF,
  parameter int POOL_WIN = POOL_WIN_DEF,
  parameter int NWIN_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [NWIN_W-1:0] num_win,
  input  logic              w_valid,
  input  logic [7:0]        w_data,
  output logic              w_ready,
  input  logic              a_valid,
  input  logic [31:0]       a_data,
  output logic              a_ready,
  output logic              busy,
  output logic              done,
`ifdef PE_FEED_PERF_EN
  output logic [15:0]       stall_cnt,
  output logic [15:0]       beat_cnt,
`endif
  output pe_state_t         pe_state_o,
  output logic [3:0][7:0]   pe_A_o,
  output logic [7:0]        pe_wrb_data_o,
  output logic [3:0]        pe_wrb_addr_o,
  output logic [3:0]        pe_wrb_o,
  output logic [3:0]        pe_rdb_addr_o
);
  seq_state_t        r_state;
  pe_in_packet_t     r_pkt;
  logic [NWIN_W-1:0] r_num_win;
  logic [3:0]        r_wcnt;
  logic              w_start, w_w_acc, w_a_acc;
  logic [3:0]        w_tap;
  logic              w_tap_last, w_win_last, w_pool_last;
  assign w_ready       = r_state == S_LOAD_W;
  assign a_ready       = r_state == S_STREAM;
  assign busy          = r_state != S_IDLE;
  assign done          = r_state == S_FIN;
  assign w_start       = r_state == S_IDLE && start;
  assign w_w_acc       = w_ready && w_valid;
  assign w_a_acc       = a_ready && a_valid;
  assign pe_state_o    = r_pkt.state;
  assign pe_A_o        = r_pkt.a;
  assign pe_wrb_data_o = r_pkt.wrb_data;
  assign pe_wrb_addr_o = r_pkt.wrb_addr;
  assign pe_wrb_o      = r_pkt.wrb;
  assign pe_rdb_addr_o = r_pkt.rdb_addr;
  pe_feed_ctr #(.KTAPS(KTAPS), .POOL_WIN(POOL_WIN), .NWIN_W(NWIN_W)) u_ctr (
    .clk        (clk),
    .reset      (reset),
    .i_clr      (w_start),
    .i_adv      (w_a_acc),
    .i_num_win  (r_num_win),
    .o_tap      (w_tap),
    .o_tap_last (w_tap_last),
    .o_win_last (w_win_last),
    .o_pool_last(w_pool_last)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_pkt     <= '0;
      r_num_win <= '0;
      r_wcnt    <= '0;
    end else begin
      r_pkt <= '0;
      if (w_w_acc)
        r_pkt <= '{state: INVALID, a: '0, wrb_data: w_data, wrb_addr: r_wcnt, wrb: '1, rdb_addr: '0};
      else if (w_a_acc)
        r_pkt <= '{state: w_tap_last ? last_tap_tag(w_pool_last) : VALID, a: a_data,
                   wrb_data: '0, wrb_addr: '0, wrb: '0, rdb_addr: w_tap};
      case (r_state)
        S_IDLE: if (start) begin
          r_num_win <= num_win;
          r_wcnt    <= '0;
          r_state   <= num_win != '0 ? S_LOAD_W : S_FIN;
        end
        S_LOAD_W: if (w_valid) begin
          r_wcnt <= r_wcnt + 4'd1;
          if (r_wcnt == 4'(KTAPS - 1)) r_state <= S_STREAM;
        end
        S_STREAM: if (a_valid && w_tap_last && w_win_last) r_state <= S_FIN;
        default: r_state <= S_IDLE;
      endcase
    end
  end
`ifdef PE_FEED_PERF_EN
  always_ff @(posedge clk) begin
    if (reset || w_start) begin
      stall_cnt <= '0;
      beat_cnt  <= '0;
    end else begin
      if (a_ready && !a_valid && stall_cnt != '1) stall_cnt <= stall_cnt + 16'd1;
      if (w_a_acc && beat_cnt != '1) beat_cnt <= beat_cnt + 16'd1;
    end
  end
`endif
endmodule
